// File: rtl/cache_array_pkg.sv
// Shared types and helpers for the cache storage arrays.
package cache_array_pkg;

  typedef enum logic {
    IDLE,
    SWEEP
  } clr_state_t;

  localparam int unsigned MAX_W = 512;
  localparam int unsigned MAX_B = MAX_W / 8;

  function automatic int unsigned byte_count(input int unsigned width);
    return width / 8;
  endfunction

  // Callers size-cast in and out; unused upper bytes are simply carried through.
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_B-1:0] mask);
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int unsigned b = 0; b < MAX_B; b++) begin
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/array_clear_seq.sv
// Clear sequencer: sweeps every array entry once, one per cycle, after a clear pulse.
module array_clear_seq
  import cache_array_pkg::*;
#(
  parameter int unsigned S_INDEX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  output logic               busy,
  output logic               sweep_en,
  output logic [S_INDEX-1:0] sweep_idx
);

  clr_state_t         state_q, state_d;
  logic [S_INDEX-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        // ptr wraps to 0 exactly as the last entry is cleared
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == SWEEP);
  assign sweep_en  = busy;
  assign sweep_idx = ptr_q;

endmodule

// File: rtl/multiport_array.sv
// Byte-maskable storage array with per-entry valid bits, N read ports and a sequenced clear.
module multiport_array
  import cache_array_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned S_INDEX    = 4,
  parameter int unsigned NUM_RPORTS = 2,
  parameter int unsigned REG_READ   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [S_INDEX-1:0]            windex,
  input  logic [WIDTH/8-1:0]            wmask,
  input  logic [WIDTH-1:0]              datain,
  input  logic [NUM_RPORTS*S_INDEX-1:0] rindex,
  output logic [NUM_RPORTS*WIDTH-1:0]   dataout,
  output logic [NUM_RPORTS-1:0]         rvalid,
  input  logic                          clear,
  output logic                          busy
);

  localparam int unsigned DEPTH = 2 ** S_INDEX;
  localparam int unsigned NB    = byte_count(WIDTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic               sweep_en;
  logic [S_INDEX-1:0] sweep_idx;
  logic               wr_en;
  logic [WIDTH-1:0]   merged;

  array_clear_seq #(
    .S_INDEX(S_INDEX)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .busy     (busy),
    .sweep_en (sweep_en),
    .sweep_idx(sweep_idx)
  );

  assign wr_en  = load && !busy;
  assign merged = WIDTH'(byte_merge(MAX_W'(mem[windex]), MAX_W'(datain),
                                    MAX_B'(wmask[NB-1:0])));

  // wr_en and sweep_en are mutually exclusive, so at most one entry changes per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid <= '0;
    end else if (sweep_en) begin
      mem[sweep_idx]   <= '0;
      valid[sweep_idx] <= 1'b0;
    end else if (wr_en) begin
      mem[windex]   <= merged;
      valid[windex] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rd
    logic [S_INDEX-1:0] ri;
    logic [WIDTH-1:0]   d;
    logic               v;

    assign ri = rindex[p*S_INDEX +: S_INDEX];

    always_comb begin
      d = mem[ri];
      v = valid[ri];
      if (sweep_en && ri == sweep_idx) begin
        d = '0;
        v = 1'b0;
      end else if (wr_en && ri == windex) begin
        d = merged;
        v = 1'b1;
      end
    end

    if (REG_READ != 0) begin : g_reg
      logic [WIDTH-1:0] d_q;
      logic             v_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          d_q <= '0;
          v_q <= 1'b0;
        end else begin
          d_q <= d;
          v_q <= v;
        end
      end
      assign dataout[p*WIDTH +: WIDTH] = d_q;
      assign rvalid[p]                 = v_q;
    end else begin : g_comb
      assign dataout[p*WIDTH +: WIDTH] = d;
      assign rvalid[p]                 = v;
    end
  end

endmodule

// File: tb/tb_multiport_array.sv
// Directed bench for multiport_array: combinational instance plus a registered-read twin.
module tb_multiport_array;

  logic        clk = 1'b0;
  logic        rst, load, clear;
  logic [3:0]  windex;
  logic [3:0]  wmask;
  logic [31:0] datain;
  logic [7:0]  rindex;
  logic [63:0] dataout, dataout_r;
  logic [1:0]  rvalid, rvalid_r;
  logic        busy, busy_r;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiport_array #(
    .WIDTH(32), .S_INDEX(4), .NUM_RPORTS(2), .REG_READ(0)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .windex(windex), .wmask(wmask),
    .datain(datain), .rindex(rindex), .dataout(dataout), .rvalid(rvalid),
    .clear(clear), .busy(busy)
  );

  multiport_array #(
    .WIDTH(32), .S_INDEX(4), .NUM_RPORTS(2), .REG_READ(1)
  ) dut_r (
    .clk(clk), .rst(rst), .load(load), .windex(windex), .wmask(wmask),
    .datain(datain), .rindex(rindex), .dataout(dataout_r), .rvalid(rvalid_r),
    .clear(clear), .busy(busy_r)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] i0, input logic [3:0] i1);
    rindex = {i1, i0};
    #1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] m);
    load = 1'b1; windex = idx; datain = d; wmask = m;
    step();
    load = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; load = 1'b0; clear = 1'b0;
    windex = '0; wmask = '0; datain = '0; rindex = '0;
    step();
    chk("rst_reg_out", 64'({rvalid_r, dataout_r}), 64'd0);
    step();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 4'(15 - i));
      chk("rst_rd", 64'({rvalid, dataout}), 64'd0);
    end

    // byte-masked merge over a full write
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3, 4'd3);
    chk("merge_d0", 64'(dataout[31:0]), 64'hDE22BE44);
    chk("merge_v0", 64'(rvalid[0]), 64'd1);
    chk("dup_port", 64'(dataout[63:32]), 64'hDE22BE44);
    step();
    chk("regrd_d0", 64'(dataout_r[31:0]), 64'hDE22BE44);

    // same-cycle write bypass
    rindex = {4'd5, 4'd6};
    load = 1'b1; windex = 4'd5; datain = 32'hCAFEF00D; wmask = 4'hF;
    #1;
    chk("byp_d1", 64'(dataout[63:32]), 64'hCAFEF00D);
    chk("byp_v1", 64'(rvalid[1]), 64'd1);
    chk("byp_p0", 64'({rvalid[0], dataout[31:0]}), 64'd0);
    step();
    load = 1'b0;
    chk("regbyp_d1", 64'(dataout_r[63:32]), 64'hCAFEF00D);

    // fill, then sweep
    for (int i = 0; i < 16; i++) wr(4'(i), 32'h10000000 + 32'(i) * 32'h111, 4'hF);
    clear = 1'b1;
    step();
    clear = 1'b0;
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      if (busy) cnt++;
      if (c == 2) begin
        load = 1'b1; windex = 4'd1; datain = 32'hFFFFFFFF; wmask = 4'hF;
      end
      if (c == 8) clear = 1'b1;
      if (c == 5) begin
        rd(4'd10, 4'd5);
        chk("sweep_old", 64'({rvalid[0], dataout[31:0]}), {31'd0, 1'b1, 32'h10000AAA});
        chk("sweep_ptr", 64'({rvalid[1], dataout[63:32]}), 64'd0);
      end
      step();
      load = 1'b0; clear = 1'b0;
    end
    chk("sweep_cnt", 64'(cnt), 64'd16);
    chk("sweep_end", 64'(busy), 64'd0);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 4'(i));
      chk("swept", 64'({rvalid, dataout}), 64'd0);
    end

    // reset aborts a sweep midway
    wr(4'd12, 32'h00000055, 4'hF);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    rd(4'd12, 4'd15);
    chk("abort_clr", 64'({rvalid, dataout}), 64'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      cnt++;
      step();
    end
    chk("resweep_cnt", 64'(cnt), 64'd16);

    // write and clear in the same cycle
    load = 1'b1; clear = 1'b1; windex = 4'd2; datain = 32'h0000ABCD; wmask = 4'hF;
    step();
    load = 1'b0; clear = 1'b0;
    rd(4'd2, 4'd2);
    chk("lc_c0", 64'({rvalid[0], dataout[31:0]}), {31'd0, 1'b1, 32'h0000ABCD});
    step();
    chk("lc_c1", 64'({rvalid[0], dataout[31:0]}), {31'd0, 1'b1, 32'h0000ABCD});
    for (int c = 0; c < 40 && busy; c++) step();
    chk("lc_busy", 64'(busy), 64'd0);
    chk("lc_end", 64'({rvalid, dataout}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiport_array.md
Name: multiport_array

Overview:
Parametrised successor to the single-port cache data/tag/valid array. It adds configurable depth, byte-masked writes, N independent read ports, per-entry valid bits, and optional registered read. It also provides a sequenced clear: a one-entry-per-cycle sweep that invalidates and zeroes the array, used on cache flush. The block sits under the cache datapath as the storage for data, tag, valid or LRU.

Parameters:
WIDTH, 32, bits per entry; must be a multiple of 8
S_INDEX, 4, index bits; depth = 2**S_INDEX
NUM_RPORTS, 2, number of independent read ports
REG_READ, 0, 0 = combinational read, 1 = one-cycle registered read

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
load  in  1  write request
windex  in  S_INDEX  write index
wmask  in  WIDTH/8  byte enables for the write
datain  in  WIDTH  write data
rindex  in  NUM_RPORTS*S_INDEX  read indices; port p uses slice [p*S_INDEX +: S_INDEX]
dataout  out  NUM_RPORTS*WIDTH  read data; port p uses slice [p*WIDTH +: WIDTH]
rvalid  out  NUM_RPORTS  valid bit of the entry read on each port
clear  in  1  start the clear sweep (pulse)
busy  out  1  sweep in progress; writes are dropped while high

Behaviour:
- Reset (rst high at a clk edge):
  - all data words become 0 and all valid bits become 0 in that single cycle;
  - FSM goes to IDLE; sweep pointer becomes 0; busy = 0;
  - REG_READ=1: dataout and rvalid registers become 0.
  - rst has priority over load and clear. rst mid-sweep aborts the sweep; the array is fully cleared anyway.
- Write acceptance:
  - a write is accepted iff load && !busy;
  - bytes with wmask[b]=1 get datain[8b+:8]; bytes with wmask[b]=0 keep their old value;
  - valid[windex] is set to 1 (even if wmask=0);
  - load while busy is silently dropped; the requester must hold until busy falls.
- Read, REG_READ=0:
  - dataout[p] = data[rindex[p]] and rvalid[p] = valid[rindex[p]], combinationally.
  - Write-through bypass: if a write is accepted this cycle and rindex[p]==windex, dataout[p] is the masked merge of the stored word and datain, and rvalid[p]=1.
- Read, REG_READ=1:
  - the outputs register the same write-first value at the clk edge;
  - latency is exactly 1 cycle from rindex to dataout/rvalid.
- Clear FSM states:
  - IDLE, with busy=0: clear=1 -> SWEEP with ptr=0. The clear edge itself zeroes nothing.
  - SWEEP, with busy=1: each cycle data[ptr]<=0, valid[ptr]<=0, ptr<=ptr+1. At ptr==2**S_INDEX-1, that entry is cleared and the FSM goes to IDLE.
  - busy is high for exactly 2**S_INDEX cycles, from the cycle after clear is sampled.
  - clear during SWEEP is ignored; the sweep does not restart.
  - The ptr counter is S_INDEX bits wide; its wrap-around coincides with the return to IDLE.
- Reads during SWEEP are permitted:
  - entries already swept, and the entry at ptr in the current cycle (bypassed), return data 0, rvalid 0;
  - entries not yet swept return their old contents.
- Simultaneous events:
  - load+clear in IDLE: the write is accepted, then the sweep starts next cycle and clears it too;
  - duplicate rindex values on different ports return identical results.
- Out-of-range conditions cannot occur, since depth is a power of two.

Decomposition:
- Shared package cache_array_pkg:
  - clear FSM state enum (IDLE, SWEEP);
  - localparam function for byte count (WIDTH/8);
  - byte-merge helper function (old, new, mask) -> merged word.
- One sub-module: array_clear_seq, which holds the FSM, the ptr counter and busy, and outputs sweep_en and sweep_idx.
- Read ports are a generate loop inside multiport_array; no separate module.

Test Plan:
- Reset, then read all indices on both ports -> dataout=0, rvalid=0 everywhere. REG_READ=1 outputs are 0 in the cycle after reset.
- Write idx 3, 0xDEADBEEF, mask 4'hF; next cycle write idx 3, 0x11223344, mask 4'b0101; port0 reads 3 -> 0xDE22BE44, rvalid=1.
- Same-cycle bypass, REG_READ=0:
  - write idx 5, 0xCAFEF00D; port1 rindex=5 in that cycle -> dataout=0xCAFEF00D, rvalid=1;
  - port0 on idx 6 is unaffected.
- Clear sweep, S_INDEX=4, all entries written:
  - pulse clear -> busy high exactly 16 cycles;
  - load during busy is dropped (entry reads 0 afterwards);
  - idx 10 read at sweep cycle 5 still shows old data; after busy falls, all rvalid=0.
- Reset at sweep cycle 7 -> busy=0 next cycle, all entries 0/invalid, a new clear starts a full 16-cycle sweep.
- load+clear same cycle, idx 2, 0x0000ABCD -> idx 2 reads 0x0000ABCD, rvalid=1 during cycle 1 of the sweep; after sweep completes it reads 0, rvalid=0.
